// File: rtl/threshold_compare.sv
// threshold_compare: step-activation front end of the neuron datapath.
// This block takes an IEEE-754 single-precision weighted sum and a threshold
// over a STB/BUSY handshake. It produces a registered 1-bit fire decision for
// the operation3 stage.
// The work is split into three steps: accept, unpack/classify, then compare.
// The result is then held until the downstream stage takes it.
module threshold_compare #(
    parameter bit GE_MODE    = 1'b1,
    parameter bit NAN_RESULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_sum,
    input  logic [31:0] input_threshold,
    input  logic        cmp_input_STB,
    output logic        cmp_BUSY,
    output logic        output_tp,
    output logic        cmp_output_STB,
    input  logic        op3_BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UNPACK  = 2'd1,
        COMPARE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] sum_q;
    logic [31:0] thr_q;
    logic        sumNan_q;
    logic        thrNan_q;
    logic        sumZero_q;
    logic        thrZero_q;
    logic        busy_q;
    logic        tp_q;
    logic        outStb_q;

    logic        sumNan_d;
    logic        thrNan_d;
    logic        sumZero_d;
    logic        thrZero_d;
    logic        isGreater;
    logic        isEqual;
    logic        tp_d;

    // Classify each latched operand as NaN or zero from its exponent and mantissa fields
    always_comb begin
        sumNan_d  = (sum_q[30:23] == 8'hFF) && (sum_q[22:0] != 23'd0);
        thrNan_d  = (thr_q[30:23] == 8'hFF) && (thr_q[22:0] != 23'd0);
        sumZero_d = (sum_q[30:23] == 8'h00) && (sum_q[22:0] == 23'd0);
        thrZero_d = (thr_q[30:23] == 8'h00) && (thr_q[22:0] == 23'd0);
    end

    // Order the operands as sign plus 31-bit magnitude; {exp,mant} is monotonic, so infinities and denormals fall out naturally
    always_comb begin
        isGreater = 1'b0;
        isEqual   = 1'b0;
        tp_d      = 1'b0;
        if (sumZero_q && thrZero_q) begin
            isEqual = 1'b1;
        end else if (sum_q[31] != thr_q[31]) begin
            isGreater = ~sum_q[31];
        end else if (sum_q[30:0] == thr_q[30:0]) begin
            isEqual = 1'b1;
        end else if (!sum_q[31]) begin
            isGreater = (sum_q[30:0] > thr_q[30:0]);
        end else begin
            isGreater = (sum_q[30:0] < thr_q[30:0]);
        end
        if (sumNan_q || thrNan_q) begin
            tp_d = NAN_RESULT;
        end else begin
            tp_d = isGreater | (GE_MODE & isEqual);
        end
    end

    // Handshake FSM: accept, unpack, compare, then hold the result until downstream is free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sum_q     <= 32'd0;
            thr_q     <= 32'd0;
            sumNan_q  <= 1'b0;
            thrNan_q  <= 1'b0;
            sumZero_q <= 1'b0;
            thrZero_q <= 1'b0;
            busy_q    <= 1'b0;
            tp_q      <= 1'b0;
            outStb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmp_input_STB && !busy_q) begin
                        sum_q   <= input_sum;
                        thr_q   <= input_threshold;
                        busy_q  <= 1'b1;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    sumNan_q  <= sumNan_d;
                    thrNan_q  <= thrNan_d;
                    sumZero_q <= sumZero_d;
                    thrZero_q <= thrZero_d;
                    state_q   <= COMPARE;
                end
                COMPARE: begin
                    tp_q     <= tp_d;
                    outStb_q <= 1'b1;
                    state_q  <= OUTPUT;
                end
                OUTPUT: begin
                    if (!op3_BUSY) begin
                        outStb_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    outStb_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmp_BUSY       = busy_q;
    assign output_tp      = tp_q;
    assign cmp_output_STB = outStb_q;

endmodule

// File: tb/tb_threshold_compare.sv
// Testbench for threshold_compare.
// Two instances share every input: one fires on >= and one fires only on >.
// This lets each equality vector exercise both modes at once.
module tb_threshold_compare;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_sum;
    logic [31:0] input_threshold;
    logic        cmp_input_STB;
    logic        op3_BUSY;

    logic        cmp_BUSY;
    logic        output_tp;
    logic        cmp_output_STB;
    logic        busyGt;
    logic        tpGt;
    logic        outStbGt;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] thr;
        logic        expGe;
        logic        expGt;
        string       name;
    } vector_t;

    vector_t vectors[14];

    threshold_compare #(.GE_MODE(1'b1), .NAN_RESULT(1'b0)) dutGe (
        .clk            (clk),
        .rst            (rst),
        .input_sum      (input_sum),
        .input_threshold(input_threshold),
        .cmp_input_STB  (cmp_input_STB),
        .cmp_BUSY       (cmp_BUSY),
        .output_tp      (output_tp),
        .cmp_output_STB (cmp_output_STB),
        .op3_BUSY       (op3_BUSY)
    );

    threshold_compare #(.GE_MODE(1'b0), .NAN_RESULT(1'b0)) dutGt (
        .clk            (clk),
        .rst            (rst),
        .input_sum      (input_sum),
        .input_threshold(input_threshold),
        .cmp_input_STB  (cmp_input_STB),
        .cmp_BUSY       (busyGt),
        .output_tp      (tpGt),
        .cmp_output_STB (outStbGt),
        .op3_BUSY       (op3_BUSY)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One full transaction from IDLE with op3_BUSY low, checking latency and the pulse shape
    task automatic applyStimulus(input vector_t v);
        input_sum       = v.sum;
        input_threshold = v.thr;
        cmp_input_STB   = 1'b1;
        @(posedge clk); #1;
        cmp_input_STB   = 1'b0;
        input_sum       = ~v.sum;
        input_threshold = ~v.thr;
        checkOutput({v.name, " busyAfterAccept"}, cmp_BUSY, 1'b1);
        @(posedge clk); #1;
        checkOutput({v.name, " stbLowE1"}, cmp_output_STB, 1'b0);
        @(posedge clk); #1;
        checkOutput({v.name, " stbHighE2"}, cmp_output_STB, 1'b1);
        checkOutput({v.name, " stbHighE2Gt"}, outStbGt, 1'b1);
        checkOutput({v.name, " tpGe"}, output_tp, v.expGe);
        checkOutput({v.name, " tpGt"}, tpGt, v.expGt);
        @(posedge clk); #1;
        checkOutput({v.name, " stbDropE3"}, cmp_output_STB, 1'b0);
        checkOutput({v.name, " busyDropE3"}, cmp_BUSY, 1'b0);
        checkOutput({v.name, " busyDropE3Gt"}, busyGt, 1'b0);
    endtask

    initial begin
        vectors[0]  = '{32'h3F800000, 32'h3F000000, 1'b1, 1'b1, "one_gt_half"};
        vectors[1]  = '{32'hC0000000, 32'hBF800000, 1'b0, 1'b0, "neg2_vs_neg1"};
        vectors[2]  = '{32'hBF800000, 32'hC0000000, 1'b1, 1'b1, "neg1_vs_neg2"};
        vectors[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, "equal_one"};
        vectors[4]  = '{32'h80000000, 32'h00000000, 1'b1, 1'b0, "negzero_poszero"};
        vectors[5]  = '{32'h7FC00000, 32'h00000000, 1'b0, 1'b0, "nan_sum"};
        vectors[6]  = '{32'h7F800000, 32'h7F7FFFFF, 1'b1, 1'b1, "inf_vs_max"};
        vectors[7]  = '{32'h00000001, 32'h00000000, 1'b1, 1'b1, "denorm_vs_zero"};
        vectors[8]  = '{32'h00000000, 32'h80000001, 1'b1, 1'b1, "zero_vs_negdenorm"};
        vectors[9]  = '{32'hFF800000, 32'hFF7FFFFF, 1'b0, 1'b0, "neginf_vs_negmax"};
        vectors[10] = '{32'h00000000, 32'hFF800001, 1'b0, 1'b0, "nan_thr"};
        vectors[11] = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, "inf_eq_inf"};
        vectors[12] = '{32'h3F800000, 32'hBF800000, 1'b1, 1'b1, "pos_vs_neg"};
        vectors[13] = '{32'h3F000000, 32'h3F800000, 1'b0, 1'b0, "half_lt_one"};

        rst             = 1'b1;
        input_sum       = 32'd0;
        input_threshold = 32'd0;
        cmp_input_STB   = 1'b0;
        op3_BUSY        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", cmp_BUSY, 1'b0);
        checkOutput("resetStb", cmp_output_STB, 1'b0);
        checkOutput("resetTp", output_tp, 1'b0);
        checkOutput("resetTpGt", tpGt, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vectors[i]);
        end

        // Backpressure: result held while downstream is busy and a second offer is ignored
        op3_BUSY        = 1'b1;
        input_sum       = 32'h3F800000;
        input_threshold = 32'h3F000000;
        cmp_input_STB   = 1'b1;
        @(posedge clk); #1;
        input_sum       = 32'hC0000000;
        input_threshold = 32'hBF800000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bpStbHeld", cmp_output_STB, 1'b1);
            checkOutput("bpTpHeld", output_tp, 1'b1);
            checkOutput("bpBusyHeld", cmp_BUSY, 1'b1);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        op3_BUSY = 1'b0;
        @(posedge clk); #1;
        checkOutput("bpStbDrop", cmp_output_STB, 1'b0);
        checkOutput("bpBusyDrop", cmp_BUSY, 1'b0);
        @(posedge clk); #1;
        checkOutput("bpQueuedAccept", cmp_BUSY, 1'b1);
        cmp_input_STB = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("bpQueuedStb", cmp_output_STB, 1'b1);
        checkOutput("bpQueuedTp", output_tp, 1'b0);
        @(posedge clk); #1;
        checkOutput("bpQueuedDone", cmp_BUSY, 1'b0);

        // Reset while in COMPARE abandons the transaction immediately
        input_sum       = 32'h3F800000;
        input_threshold = 32'h3F000000;
        cmp_input_STB   = 1'b1;
        @(posedge clk); #1;
        cmp_input_STB = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAsyncBusy", cmp_BUSY, 1'b0);
        checkOutput("rstAsyncStb", cmp_output_STB, 1'b0);
        checkOutput("rstAsyncTp", output_tp, 1'b0);
        @(posedge clk); #6;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("rstNoResultStb", cmp_output_STB, 1'b0);
            checkOutput("rstNoResultBusy", cmp_BUSY, 1'b0);
        end
        applyStimulus(vectors[2]);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
